mips_debug_unit: RTL and testbench
==================================

# mips_debug_unit

Byte-stream debug controller that sits between the UART receiver/transmitter pair and the pipelined MIPS core. It loads program words into the core's instruction memory, runs the core continuously until halt or advances it one clock per step command, and reports PC and executed-cycle count back to the host. It is the sole driver of the core's instruction-memory write port, reset and clock-enable.

## Interface
- CMD_LOAD, 8'h4C, opcode: load program words
- CMD_RUN, 8'h52, opcode: run until halt
- CMD_STEP, 8'h53, opcode: advance one cycle
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle pulse, rx_data valid
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle pulse, start transmitting tx_data
- tx_done  in  1  one-cycle pulse, transmitter finished current byte
- halt_flag  in  1  core has retired a halt instruction (level)
- out_pc  in  32  core program counter
- mips_enable  out  1  core clock-enable; pipeline advances in cycles where high
- mips_reset  out  1  synchronous reset to core, active-high
- wea_ram_inst  out  1  instruction-memory write enable (one-cycle pulse)
- in_addr_mem_inst  out  32  instruction-memory byte address
- in_ins_to_mem  out  32  instruction word to write
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, REP_SEND, REP_WAIT.
- IDLE: on rx_valid, CMD_LOAD -> LOAD_CNT; CMD_RUN -> RUN; CMD_STEP -> STEP; any other byte dropped, stay IDLE.
- LOAD_CNT: next rx byte is word count N (0 means 256). Clear address to 0, cycle counter to 0, byte index to 0; assert mips_reset. -> LOAD_BYTE.
- LOAD_BYTE: shift bytes into 32-bit assembly register MSB first (first byte -> bits 31:24). After 4th byte -> LOAD_WR.
- LOAD_WR: one cycle: wea_ram_inst=1, in_ins_to_mem=assembled word, in_addr_mem_inst=current address. Next cycle address += 4, remaining count -1. Remaining nonzero -> LOAD_BYTE, else -> IDLE and deassert mips_reset.
- RUN: mips_enable=1 every cycle while halt_flag=0; cycle counter +1 per enabled cycle (32-bit, wraps). When halt_flag=1 (sampled), mips_enable=0 that cycle -> REP_SEND. RUN entered with halt_flag already 1: zero enabled cycles, straight to report.
- STEP: mips_enable=1 for exactly one cycle (unless halt_flag=1, then 0), counter +1 if enabled, -> REP_SEND.
- REP_SEND/REP_WAIT: on report entry snapshot out_pc and counter into 64-bit shift register. Send 8 bytes: PC[31:24]..PC[7:0], then CNT[31:24]..CNT[7:0]. REP_SEND pulses tx_start one cycle with byte; REP_WAIT waits for tx_done; after 8th tx_done -> IDLE.
- rx_valid in RUN, STEP, REP_SEND, REP_WAIT, LOAD_WR: byte dropped, no state effect.

## Timing
- Reset values: state IDLE, mips_enable=0, mips_reset=0, wea_ram_inst=0, in_addr_mem_inst=0, in_ins_to_mem=0, tx_start=0, tx_data=0, busy=0, counter=0.
- All outputs registered.
- Load: wea_ram_inst high the cycle after the 4th byte's rx_valid; address update visible the cycle after wea.
- mips_reset high from cycle after count byte until cycle after last LOAD_WR.
- Step: mips_enable high exactly one cycle, two cycles after STEP byte's rx_valid; first tx_start no earlier than cycle after that.
- tx_start never asserted while a previous byte awaits tx_done.
- tx_done outside REP_WAIT ignored.
- Reset mid-operation: all outputs return to reset values immediately (async), partial load/report discarded; instruction memory contents untouched.

## Test plan
- Reset mid-load: send 4C 02 and 3 bytes, assert reset -> wea never pulses, busy=0, mips_reset=0; next command processed normally.
- Load: send 4C 02 20 01 00 05 FC 00 00 00 -> two wea pulses: addr 0 data 32'h20010005, addr 4 data 32'hFC000000; mips_reset high throughout, low after; busy returns 0.
- Step: after load, halt_flag=0, out_pc=4, send 53 -> one mips_enable cycle, 8 tx bytes 00 00 00 04 00 00 00 01, each only after prior tx_done.
- Run to halt: send 52, model raises halt_flag after 10 enabled cycles with out_pc=32'h24 -> mips_enable high exactly 10 cycles, report 00 00 00 24 00 00 00 0B (includes prior step).
- Run when halted: halt_flag=1, send 52 -> mips_enable never high, report with unchanged counter.
- Noise: bytes 41 and 52-during-report -> 41 ignored in IDLE; byte during report dropped, no second report.

Source files
------------

// File: rtl/mips_debug_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_debug_unit_if
// Purpose  : Host byte stream, transmitter handshake and core control bundle
//            for the MIPS debug unit.
// Revision : 1.0
// ============================================================================
interface mips_debug_unit_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        halt_flag;
    logic [31:0] out_pc;
    logic        mips_enable;
    logic        mips_reset;
    logic        wea_ram_inst;
    logic [31:0] in_addr_mem_inst;
    logic [31:0] in_ins_to_mem;
    logic        busy;

    // Debug unit side: drives the core controls and the transmitter.
    modport master (
        input  rx_data, rx_valid, tx_done, halt_flag, out_pc,
        output tx_data, tx_start, mips_enable, mips_reset,
               wea_ram_inst, in_addr_mem_inst, in_ins_to_mem, busy
    );

    // Host/core side: supplies bytes, transmitter status and core state.
    modport slave (
        output rx_data, rx_valid, tx_done, halt_flag, out_pc,
        input  tx_data, tx_start, mips_enable, mips_reset,
               wea_ram_inst, in_addr_mem_inst, in_ins_to_mem, busy
    );
endinterface
`default_nettype wire

// File: rtl/mips_debug_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_debug_unit
// Purpose  : UART-byte-driven loader, run/step controller and PC/cycle
//            reporter for the pipelined MIPS core.
// Revision : 1.0
// ============================================================================
module mips_debug_unit (
    input  logic               clk,
    input  logic               reset,
    mips_debug_unit_if.master  bus
);
    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_CNT  = 3'd1,
        S_LOAD_BYTE = 3'd2,
        S_LOAD_WR   = 3'd3,
        S_RUN       = 3'd4,
        S_STEP      = 3'd5,
        S_REP_SEND  = 3'd6,
        S_REP_WAIT  = 3'd7
    } state_t;

    state_t      state_q,    state_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] ins_q,      ins_d;
    logic        wea_q,      wea_d;
    logic [31:0] asm_q,      asm_d;
    logic [8:0]  remain_q,   remain_d;
    logic [2:0]  idx_q,      idx_d;
    logic [31:0] cnt_q,      cnt_d;
    logic [63:0] shift_q,    shift_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        en_q,       en_d;
    logic        mrst_q,     mrst_d;
    logic        busy_q,     busy_d;

    logic [31:0] cnt_inc;
    logic [31:0] word_next;

    assign cnt_inc   = cnt_q + 32'd1;
    assign word_next = {asm_q[23:0], bus.rx_data};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ins_d      = ins_q;
        wea_d      = 1'b0;
        asm_d      = asm_q;
        remain_d   = remain_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        en_d       = 1'b0;
        mrst_d     = mrst_q;

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        CMD_LOAD: state_d = S_LOAD_CNT;
                        CMD_RUN:  state_d = S_RUN;
                        CMD_STEP: state_d = S_STEP;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_LOAD_CNT: begin
                if (bus.rx_valid) begin
                    // A count byte of zero stands for a full 256-word image.
                    remain_d = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                    addr_d   = 32'd0;
                    cnt_d    = 32'd0;
                    idx_d    = 3'd0;
                    mrst_d   = 1'b1;
                    state_d  = S_LOAD_BYTE;
                end
            end
            S_LOAD_BYTE: begin
                if (bus.rx_valid) begin
                    asm_d = word_next;
                    if (idx_q == 3'd3) begin
                        idx_d   = 3'd0;
                        wea_d   = 1'b1;
                        ins_d   = word_next;
                        state_d = S_LOAD_WR;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_LOAD_WR: begin
                addr_d   = addr_q + 32'd4;
                remain_d = remain_q - 9'd1;
                if (remain_q == 9'd1) begin
                    mrst_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD_BYTE;
                end
            end
            S_RUN: begin
                if (!bus.halt_flag) begin
                    en_d  = 1'b1;
                    cnt_d = cnt_inc;
                end else begin
                    shift_d = {bus.out_pc, cnt_q};
                    idx_d   = 3'd0;
                    state_d = S_REP_SEND;
                end
            end
            S_STEP: begin
                // The snapshot must already include this step's cycle.
                if (!bus.halt_flag) begin
                    en_d    = 1'b1;
                    cnt_d   = cnt_inc;
                    shift_d = {bus.out_pc, cnt_inc};
                end else begin
                    shift_d = {bus.out_pc, cnt_q};
                end
                idx_d   = 3'd0;
                state_d = S_REP_SEND;
            end
            S_REP_SEND: begin
                tx_start_d = 1'b1;
                tx_data_d  = shift_q[63:56];
                state_d    = S_REP_WAIT;
            end
            S_REP_WAIT: begin
                if (bus.tx_done) begin
                    shift_d = {shift_q[55:0], 8'h00};
                    if (idx_q == 3'd7) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_REP_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'd0;
            ins_q      <= 32'd0;
            wea_q      <= 1'b0;
            asm_q      <= 32'd0;
            remain_q   <= 9'd0;
            idx_q      <= 3'd0;
            cnt_q      <= 32'd0;
            shift_q    <= 64'd0;
            tx_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
            en_q       <= 1'b0;
            mrst_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ins_q      <= ins_d;
            wea_q      <= wea_d;
            asm_q      <= asm_d;
            remain_q   <= remain_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            en_q       <= en_d;
            mrst_q     <= mrst_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.tx_data          = tx_data_q;
    assign bus.tx_start         = tx_start_q;
    assign bus.mips_enable      = en_q;
    assign bus.mips_reset       = mrst_q;
    assign bus.wea_ram_inst     = wea_q;
    assign bus.in_addr_mem_inst = addr_q;
    assign bus.in_ins_to_mem    = ins_q;
    assign bus.busy             = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_mips_debug_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_debug_unit
// Purpose  : Directed bench for mips_debug_unit with host/transmitter/core
//            models and an every-cycle output checker.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mips_debug_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_debug_unit_if bus();
    mips_debug_unit dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected instruction writes {addr, data} and expected report bytes.
    logic [63:0] exp_wr[$];
    logic [7:0]  exp_tx[$];

    // Core model controls (driven from the stimulus process only).
    logic        halt_force;
    logic [31:0] pc_force;
    logic        run_armed;
    int          en_base;

    // Observation state (written only by the checker process).
    int          en_total    = 0;
    int          last_en_cyc = 0;
    int          wr_seen     = 0;
    int          tx_seen     = 0;
    logic [63:0] rep_shift   = 64'd0;
    logic        tx_pending  = 1'b0;
    int          tx_timer    = 0;
    logic        tx_done_r   = 1'b0;

    // The core halts once it has executed ten enabled cycles of an armed run.
    logic run_hit;
    assign run_hit       = run_armed && ((en_total - en_base) >= 10);
    assign bus.halt_flag = halt_force | run_hit;
    assign bus.out_pc    = run_hit ? 32'h24 : pc_force;
    assign bus.tx_done   = tx_done_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            tx_pending = 1'b0;
            tx_timer   = 0;
            tx_done_r  = 1'b0;
        end else begin
            tx_done_r = 1'b0;
            if (tx_timer != 0) begin
                tx_timer--;
                if (tx_timer == 0) begin
                    tx_done_r  = 1'b1;
                    tx_pending = 1'b0;
                end
            end
            if (bus.tx_start) begin
                check("tx_start_while_pending", {63'd0, tx_pending}, 64'd0);
                if (exp_tx.size() == 0) check("tx_unexpected_byte", 64'd1, 64'd0);
                else check("tx_byte", {56'd0, bus.tx_data}, {56'd0, exp_tx.pop_front()});
                rep_shift  = {rep_shift[55:0], bus.tx_data};
                tx_seen++;
                tx_pending = 1'b1;
                tx_timer   = 3;
            end
            if (bus.wea_ram_inst) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_wr.pop_front();
                    check("wr_addr", {32'd0, bus.in_addr_mem_inst}, {32'd0, e[63:32]});
                    check("wr_data", {32'd0, bus.in_ins_to_mem}, {32'd0, e[31:0]});
                end
                check("wr_mips_reset", {63'd0, bus.mips_reset}, 64'd1);
            end
            if (bus.mips_enable) begin
                en_total++;
                last_en_cyc = cyc;
            end
        end
    end

    int rx_cyc;
    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        rx_cyc       = cyc;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        repeat (2) @(negedge clk);
        while (bus.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'd0, bus.busy}, 64'd0);
    endtask

    task automatic push_report(input logic [31:0] pc, input logic [31:0] cnt);
        logic [63:0] r;
        r = {pc, cnt};
        for (int i = 7; i >= 0; i--) exp_tx.push_back(r[i*8 +: 8]);
    endtask

    int          model_cnt;
    int          tx_base;
    int          wr_base;
    logic [7:0]  img[8];

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        halt_force   = 1'b0;
        pc_force     = 32'd0;
        run_armed    = 1'b0;
        en_base      = 0;
        model_cnt    = 0;
        rx_cyc       = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     {63'd0, bus.busy},         64'd0);
        check("rst_enable",   {63'd0, bus.mips_enable},  64'd0);
        check("rst_mreset",   {63'd0, bus.mips_reset},   64'd0);
        check("rst_wea",      {63'd0, bus.wea_ram_inst}, 64'd0);
        check("rst_addr",     {32'd0, bus.in_addr_mem_inst}, 64'd0);
        check("rst_ins",      {32'd0, bus.in_ins_to_mem},    64'd0);
        check("rst_tx_start", {63'd0, bus.tx_start},     64'd0);
        check("rst_tx_data",  {56'd0, bus.tx_data},      64'd0);
        @(negedge clk) reset = 1'b0;

        // Abort a load part-way through its first word.
        wr_base = wr_seen;
        send(8'h4C); send(8'h02); send(8'h20); send(8'h01); send(8'h00);
        #2 reset = 1'b1;
        #1;
        check("midload_busy",   {63'd0, bus.busy},       64'd0);
        check("midload_mreset", {63'd0, bus.mips_reset}, 64'd0);
        check("midload_wea",    {63'd0, bus.wea_ram_inst}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("midload_no_write", 64'(wr_seen - wr_base), 64'd0);

        // Two-word program load.
        img = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
        exp_wr.push_back({32'd0, 32'h20010005});
        exp_wr.push_back({32'd4, 32'hFC000000});
        wr_base = wr_seen;
        send(8'h4C); send(8'h02);
        check("load_mreset_on", {63'd0, bus.mips_reset}, 64'd1);
        for (int i = 0; i < 8; i++) send(img[i]);
        wait_idle("load_idle");
        check("load_writes",     64'(wr_seen - wr_base), 64'd2);
        check("load_mreset_off", {63'd0, bus.mips_reset}, 64'd0);
        check("load_addr_end",   {32'd0, bus.in_addr_mem_inst}, 64'd8);
        model_cnt = 0;

        // Single step.
        pc_force  = 32'd4;
        en_base   = en_total;
        tx_base   = tx_seen;
        model_cnt = model_cnt + 1;
        push_report(pc_force, model_cnt);
        send(8'h53);
        wait_idle("step_idle");
        check("step_enables",   64'(en_total - en_base), 64'd1);
        check("step_en_delay",  64'(last_en_cyc - rx_cyc), 64'd2);
        check("step_tx_count",  64'(tx_seen - tx_base), 64'd8);
        check("step_report",    rep_shift, 64'h00000004_00000001);
        check("step_queue",     64'(exp_tx.size()), 64'd0);

        // Run until the core model halts after ten cycles.
        en_base   = en_total;
        tx_base   = tx_seen;
        run_armed = 1'b1;
        model_cnt = model_cnt + 10;
        push_report(32'h24, model_cnt);
        send(8'h52);
        wait_idle("run_idle");
        check("run_enables",  64'(en_total - en_base), 64'd10);
        check("run_tx_count", 64'(tx_seen - tx_base), 64'd8);
        check("run_report",   rep_shift, 64'h00000024_0000000B);
        halt_force = 1'b1;
        pc_force   = 32'h24;
        run_armed  = 1'b0;

        // Run with the core already halted.
        en_base = en_total;
        tx_base = tx_seen;
        push_report(32'h24, model_cnt);
        send(8'h52);
        wait_idle("halted_idle");
        check("halted_enables",  64'(en_total - en_base), 64'd0);
        check("halted_tx_count", 64'(tx_seen - tx_base), 64'd8);
        check("halted_report",   rep_shift, 64'h00000024_0000000B);

        // Unknown byte in IDLE, then a command byte arriving mid-report.
        tx_base = tx_seen;
        send(8'h41);
        repeat (5) @(negedge clk);
        check("noise_idle_busy", {63'd0, bus.busy}, 64'd0);
        push_report(32'h24, model_cnt);
        send(8'h52);
        begin
            int n = 0;
            while (!tx_pending && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("noise_report_started", {63'd0, tx_pending}, 64'd1);
        end
        send(8'h52);
        wait_idle("noise_idle");
        repeat (40) @(negedge clk);
        check("noise_tx_count", 64'(tx_seen - tx_base), 64'd8);
        check("noise_busy",     {63'd0, bus.busy}, 64'd0);
        check("noise_queue",    64'(exp_tx.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
